// File: rtl/stripe_scheduler.sv
// stripe_scheduler: deals a valid/ready byte stream round-robin onto LANES
// output lanes. Each lane has its own credit counter, so a lane without
// credit stalls the whole stream and bytes are never reordered.
module stripe_scheduler #(
  parameter int LANES   = 2,
  parameter int CREDITS = 4,
  parameter int CW      = 3,
  parameter int PW      = 1
) (
  input  logic               clk_2f,
  input  logic               reset,
  input  logic               enable,
  input  logic               align,
  input  logic               valid_in,
  input  logic [7:0]         data_in,
  output logic               ready_out,
  input  logic [LANES-1:0]   credit_ret,
  output logic [8*LANES-1:0] lane_data,
  output logic [LANES-1:0]   lane_valid,
  output logic [PW-1:0]      lane_ptr,
  output logic [1:0]         state,
  output logic               err_credit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  logic [CW-1:0]      credit_q [LANES];
  logic [CW-1:0]      credit_d [LANES];
  logic [PW-1:0]      lane_ptr_q, lane_ptr_d;
  logic [8*LANES-1:0] lane_data_q, lane_data_d;
  logic [LANES-1:0]   lane_valid_q, lane_valid_d;
  logic               err_q, err_d;
  state_t             state_q, state_d;

  logic               cur_has_credit_s;
  logic               ready_s;
  logic               accept_s;
  logic [LANES-1:0]   consume_s;

  // The lane currently pointed at gates the whole stream.
  assign cur_has_credit_s = (credit_q[lane_ptr_q] != {CW{1'b0}});
  assign ready_s          = !reset && enable && cur_has_credit_s;
  assign accept_s         = valid_in && ready_s;

  assign ready_out  = ready_s;
  assign lane_data  = lane_data_q;
  assign lane_valid = lane_valid_q;
  assign lane_ptr   = lane_ptr_q;
  assign state      = state_q;
  assign err_credit = err_q;

  // Decode which lane (if any) consumes a credit this cycle; at most one bit set.
  always_comb begin
    consume_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      consume_s[i] = accept_s && (lane_ptr_q == PW'(i));
    end
  end

  // Credit bookkeeping: consume and return in the same cycle cancel out;
  // a lone return on a full counter saturates and raises the sticky error.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < LANES; i++) begin
      credit_d[i] = credit_q[i];
      case ({consume_s[i], credit_ret[i]})
        2'b10: credit_d[i] = credit_q[i] - CW'(1);
        2'b01: begin
          if (credit_q[i] == CW'(CREDITS)) begin
            err_d = 1'b1;
          end else begin
            credit_d[i] = credit_q[i] + CW'(1);
          end
        end
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Lane data capture, one-cycle strobe and round-robin pointer (align wins).
  always_comb begin
    lane_data_d  = lane_data_q;
    lane_valid_d = consume_s;
    for (int i = 0; i < LANES; i++) begin
      if (consume_s[i]) begin
        lane_data_d[8*i +: 8] = data_in;
      end else begin
        lane_data_d[8*i +: 8] = lane_data_q[8*i +: 8];
      end
    end
    if (align) begin
      lane_ptr_d = {PW{1'b0}};
    end else if (accept_s) begin
      if (lane_ptr_q == PW'(LANES - 1)) begin
        lane_ptr_d = {PW{1'b0}};
      end else begin
        lane_ptr_d = lane_ptr_q + PW'(1);
      end
    end else begin
      lane_ptr_d = lane_ptr_q;
    end
  end

  // Informational FSM: tracks idle / streaming / waiting on credit.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (valid_in && !cur_has_credit_s) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          if (cur_has_credit_s || !valid_in) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STALL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; reset also drops any pending strobe.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      lane_data_q  <= {(8*LANES){1'b0}};
      lane_valid_q <= {LANES{1'b0}};
      lane_ptr_q   <= {PW{1'b0}};
      err_q        <= 1'b0;
      state_q      <= ST_IDLE;
      for (int i = 0; i < LANES; i++) begin
        credit_q[i] <= CW'(CREDITS);
      end
    end else begin
      lane_data_q  <= lane_data_d;
      lane_valid_q <= lane_valid_d;
      lane_ptr_q   <= lane_ptr_d;
      err_q        <= err_d;
      state_q      <= state_d;
      for (int i = 0; i < LANES; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_stripe_scheduler.sv
// Testbench for stripe_scheduler: directed scenarios plus a random phase,
// checked against a byte-count based reference model and a strobe scoreboard.
module tb_stripe_scheduler;

  localparam int LANES   = 2;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
  localparam int PW      = 1;

  logic               clk_2f = 1'b0;
  logic               reset;
  logic               enable;
  logic               align;
  logic               valid_in;
  logic [7:0]         data_in;
  logic               ready_out;
  logic [LANES-1:0]   credit_ret;
  logic [8*LANES-1:0] lane_data;
  logic [LANES-1:0]   lane_valid;
  logic [PW-1:0]      lane_ptr;
  logic [1:0]         state;
  logic               err_credit;

  stripe_scheduler #(.LANES(LANES), .CREDITS(CREDITS), .CW(CW), .PW(PW)) dut (
    .clk_2f(clk_2f), .reset(reset), .enable(enable), .align(align),
    .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
    .credit_ret(credit_ret), .lane_data(lane_data), .lane_valid(lane_valid),
    .lane_ptr(lane_ptr), .state(state), .err_credit(err_credit)
  );

  always #5 clk_2f = ~clk_2f;

  int errors = 0;
  int checks = 0;

  // Scoreboard: lane*256 + byte for every accepted byte, in acceptance order.
  int exp_q[$];
  logic mon_en = 1'b0;

  // Reference model: lane of byte k = (k - base) mod LANES, base set by align/reset.
  int         m_cred [LANES];
  logic [7:0] m_data [LANES];
  int         m_nacc, m_base, m_err, m_state;

  function automatic int cur_ptr();
    return (m_nacc - m_base) % LANES;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_cred[i] = CREDITS;
      m_data[i] = 8'h00;
    end
    m_nacc = 0; m_base = 0; m_err = 0; m_state = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must be one-hot and match the oldest expected byte.
  int mon_lane;
  int mon_exp;
  always @(negedge clk_2f) begin
    if (mon_en && lane_valid !== {LANES{1'b0}}) begin
      mon_lane = -1;
      for (int i = 0; i < LANES; i++) if (lane_valid[i] === 1'b1) mon_lane = i;
      checks++;
      if (!$onehot(lane_valid) || mon_lane < 0) begin
        errors++;
        $display("FAIL strobe_onehot: got %b expected one-hot", lane_valid);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got lane %0d byte %0h expected no strobe",
                 mon_lane, lane_data[8*mon_lane +: 8]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp != mon_lane*256 + int'(lane_data[8*mon_lane +: 8])) begin
          errors++;
          $display("FAIL strobe_data: got lane %0d byte %0h expected lane %0d byte %0h",
                   mon_lane, lane_data[8*mon_lane +: 8], mon_exp/256, mon_exp%256);
        end
      end
    end
  end

  // One clock cycle: drive inputs, check registered outputs and ready_out, advance model.
  task automatic step(input logic v, input logic [7:0] d, input logic [LANES-1:0] r,
                      input logic al, input logic en, input logic rs);
    logic               exp_rdy;
    logic               acc;
    logic               c;
    int                 p;
    logic [8*LANES-1:0] eld;
    @(negedge clk_2f);
    valid_in = v; data_in = d; credit_ret = r; align = al; enable = en; reset = rs;
    #1;
    p = cur_ptr();
    for (int i = 0; i < LANES; i++) eld[8*i +: 8] = m_data[i];
    chk("missed_strobe", exp_q.size(), 0);
    chk("lane_ptr", lane_ptr, p);
    chk("state", state, m_state);
    chk("err_credit", err_credit, m_err);
    chk("lane_data", lane_data, eld);
    exp_rdy = !rs && en && (m_cred[p] != 0);
    chk("ready_out", ready_out, exp_rdy);
    acc = v && exp_rdy;
    if (rs) begin
      model_reset();
    end else begin
      if (!en)                m_state = 0;
      else if (m_state == 0)  m_state = 1;
      else if (m_state == 1)  m_state = (v && m_cred[p] == 0) ? 2 : 1;
      else                    m_state = (m_cred[p] != 0 || !v) ? 1 : 2;
      for (int i = 0; i < LANES; i++) begin
        c = acc && (i == p);
        if (c && !r[i]) m_cred[i]--;
        else if (r[i] && !c) begin
          if (m_cred[i] == CREDITS) m_err = 1;
          else m_cred[i]++;
        end
      end
      if (acc) begin
        exp_q.push_back(p*256 + int'(d));
        m_data[p] = d;
        m_nacc++;
      end
      if (al) m_base = m_nacc;
    end
  endtask

  task automatic idle();
    step(1'b0, 8'h00, {LANES{1'b0}}, 1'b0, 1'b1, 1'b0);
  endtask

  // Offer one byte until taken, returning a credit to the target lane each try.
  task automatic send(input logic [7:0] d, input logic al);
    int n0;
    logic [LANES-1:0] rb;
    n0 = m_nacc;
    for (int k = 0; k < 8 && m_nacc == n0; k++) begin
      rb = {LANES{1'b0}};
      rb[cur_ptr()] = 1'b1;
      step(1'b1, d, rb, al, 1'b1, 1'b0);
    end
    chk("send_accepted", m_nacc - n0, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; align = 1'b0; valid_in = 1'b0;
    data_in = 8'h00; credit_ret = {LANES{1'b0}};
    model_reset();
    repeat (2) @(posedge clk_2f);
    mon_en = 1'b1;

    // Reset values, then stream 0x10..0x17 with credits returned every cycle.
    idle();
    for (int k = 0; k < 8; k++) send(8'(8'h10 + k), 1'b0);
    idle();

    // Exhaust lane 1 (lane 0 keeps being refilled), stall, then one return.
    for (int k = 0; k < 9; k++)
      step(1'b1, 8'(8'h20 + k), (cur_ptr() == 0) ? 2'b01 : 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h29, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h29, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h29, 2'b10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h29, 2'b00, 1'b0, 1'b1, 1'b0);
    idle();

    // Align while lane_ptr is 1.
    if (cur_ptr() == 0) send(8'h30, 1'b0);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    idle();

    // Consume+return at credit 1, then overflow the lane-0 counter.
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    idle();
    for (int k = 0; k < 5; k++)
      step(1'b1, 8'(8'h40 + k), (cur_ptr() == 1) ? 2'b10 : 2'b00, 1'b0, 1'b1, 1'b0);
    send(8'h45, 1'b0);
    step(1'b1, 8'h46, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0);
    repeat (3) idle();
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    idle();

    // Drop enable mid-stream, then resume.
    send(8'h50, 1'b0); send(8'h51, 1'b0); send(8'h52, 1'b0);
    step(1'b1, 8'h53, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h53, 2'b00, 1'b0, 1'b0, 1'b0);
    send(8'h53, 1'b0); send(8'h54, 1'b0); send(8'h55, 1'b0);

    // Reset during a burst, then spend exactly CREDITS per lane without returns.
    send(8'h60, 1'b0); send(8'h61, 1'b0); send(8'h62, 1'b0);
    step(1'b1, 8'h63, 2'b00, 1'b0, 1'b1, 1'b1);
    idle();
    for (int k = 0; k < 2*CREDITS + 1; k++)
      step(1'b1, 8'(8'h70 + k), 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0);
    idle();

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      step(1'($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 2) == 0) ? LANES'($urandom) : {LANES{1'b0}},
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 149) == 0));
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stripe_scheduler.md
# stripe_scheduler

Sequencing controller for the transmit byte-striping datapath. It accepts a single byte stream with a valid/ready handshake and deals bytes round-robin onto LANES parallel lanes. Each lane has a credit counter so a slow downstream lane stalls the stream without reordering bytes. It runs on the byte-rate clock ahead of the per-lane serializers.

## Interface
- LANES, 2, number of output lanes (≥2)
- CREDITS, 4, initial and maximum credits per lane (1..2^CW−1)
- CW, 3, width of each credit counter
- PW, 1, width of lane pointer, = ceil(log2(LANES))

Ports:
- clk_2f  in  1  byte-rate clock; all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  scheduler run enable
- align  in  1  single-cycle pulse; forces next byte onto lane 0
- valid_in  in  1  upstream byte valid
- data_in  in  8  upstream byte
- ready_out  out  1  scheduler can take data_in this cycle (combinational)
- credit_ret  in  LANES  bit i pulse = one credit returned by lane i
- lane_data  out  8*LANES  registered byte per lane, lane i at [8i+7:8i]
- lane_valid  out  LANES  one-cycle strobe per lane
- lane_ptr  out  PW  lane receiving the next accepted byte
- state  out  2  0=IDLE, 1=RUN, 2=STALL
- err_credit  out  1  sticky credit-overflow flag

## Operation
- Reset (reset=1 at posedge) sets: lane_data=0, lane_valid=0, lane_ptr=0, every credit counter=CREDITS, err_credit=0, state=IDLE. ready_out=0 while reset is high.
- ready_out = !reset && enable && (credit[lane_ptr] != 0).
- Accept = valid_in && ready_out. On accept:
  - lane_data[lane_ptr] <= data_in; lane_valid bit lane_ptr <= 1.
  - credit[lane_ptr] decrements.
  - lane_ptr <= (lane_ptr+1) mod LANES. Wrap is from LANES−1 to 0.
- No accept: lane_valid <= 0. lane_data holds its last value and lane_ptr holds.
- Only one lane_valid bit is ever high in a cycle.
- credit_ret[i] increments credit[i]. If the same lane consumes and returns a credit in the same cycle, the count is unchanged.
- Credit overflow: a return when credit[i]==CREDITS and there is no same-cycle consume leaves the counter saturated at CREDITS and sets err_credit, which stays set until reset.
- align: lane_ptr <= 0 at the next edge, overriding the increment. A byte accepted in the align cycle still goes to the old lane_ptr.
- enable=0: ready_out=0; lane_ptr and credits still update from align and credit_ret.
- FSM (registered, evaluated each posedge with the new inputs):
  - Any state goes to IDLE when enable=0.
  - IDLE goes to RUN when enable=1.
  - RUN goes to STALL when valid_in=1 and credit[lane_ptr]==0.
  - STALL goes to RUN when credit[lane_ptr]!=0 or valid_in=0.
  - state is informational only; ready_out does not depend on it.

## Timing
- Latency: a byte accepted at edge N appears on lane_data and lane_valid after edge N, for exactly one cycle.
- Throughput: one byte per cycle while the target lanes have credit.
- Credits returned at edge N are usable for an accept in cycle N+1. ready_out rises in the same cycle the counter becomes non-zero.
- A reset asserted mid-stream discards any in-flight strobe: lane_valid=0 on the next cycle, and no partial lane update occurs.
- Bytes leave in strict input order across lanes: byte k goes to lane (k + offset) mod LANES, where offset is fixed by the last align or reset.

## Test plan
- Reset, enable=1, stream 0x10..0x17 back-to-back with credits returned every cycle. Required: lane 0 gets 0x10,0x12,0x14,0x16 and lane 1 gets 0x11,0x13,0x15,0x17, each with a 1-cycle lane_valid one cycle after accept; ready_out stays 1.
- Credit exhaustion on lane 1 with no returns. Required: after 4 bytes on lane 1, the next lane-1 byte sees ready_out=0 and state=STALL. Pulse credit_ret[1]; required: ready_out=1 in the following cycle, the byte is accepted, and state returns to RUN.
- Pulse align when lane_ptr=1 while accepting 0xAA. Required: 0xAA goes to lane 1, the next byte 0xBB goes to lane 0, and lane_ptr reads 1 afterwards.
- Simultaneous consume and return on lane 0 at credit=1. Required: credit stays 1 and no err_credit. Then return a credit to lane 0 at credit=CREDITS with no consume; required: err_credit=1, it stays high, and it clears only on reset.
- Drop enable mid-stream. Required: ready_out=0 and state=IDLE next cycle, with no lane_valid. Re-enable; required: streaming resumes on the held lane_ptr with the order preserved.
- Assert reset during a burst. Required: all outputs take their reset values next cycle, credits read 4 per lane, and lane_ptr=0.
